// File: rtl/power_seq_pkg.sv
// power_seq_pkg: shared state encoding and default timing constants for the power sequencer
package power_seq_pkg;
  localparam int SETTLE_CYC_DEF = 4;
  localparam int ACK_TIMEOUT_DEF = 64;
  localparam int CNT_W = 16;
  typedef enum logic [3:0] {
    ON = 4'd0, CLK_OFF, ISO, SAVE, SW_OFF, OFF, SW_ON, RST_HOLD, RESTORE, ISO_REL
  } pwr_state_e;
endpackage

// File: rtl/pwr_seq_timer.sv
// pwr_seq_timer: per-state cycle counter, cleared on state entry, saturating, with limit compare
module pwr_seq_timer
  import power_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] limit,
  output logic             done
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= '0;
    else if (cnt != '1) cnt <= cnt + 1'b1;
  assign done = cnt == limit;
endmodule

// File: rtl/power_seq_ctrl.sv
// power_seq_ctrl: power-domain down/up sequencer (clock gate, isolation, retention, switch, reset)
module power_seq_ctrl
  import power_seq_pkg::*;
#(
  parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pwr_req,
  input  logic       dom_idle,
  input  logic       sw_ack,
  output logic       clk_en,
  output logic       iso_en,
  output logic       save,
  output logic       restore,
  output logic       sw_en,
  output logic       dom_rst_n,
  output logic       pwr_on,
  output logic       pwr_off,
  output logic       err,
  output logic [3:0] state_o
);
  pwr_state_e state, nxt;
  logic done, ack_wait, timeout;
  assign ack_wait = state inside {SW_OFF, SW_ON};
  // awaited ack level is 0 in SW_OFF and 1 in SW_ON; a timeout is the opposite level at the limit
  assign timeout = ack_wait && done && (sw_ack == (state == SW_OFF));
  pwr_seq_timer u_timer (
    .clk,
    .rst_n,
    .load (nxt != state),
    .limit(ack_wait ? CNT_W'(ACK_TIMEOUT - 1) : CNT_W'(SETTLE_CYC - 1)),
    .done
  );
  always_comb begin
    nxt = state;
    case (state)
      ON:       nxt = (!pwr_req && dom_idle) ? CLK_OFF : ON;
      CLK_OFF:  nxt = done ? ISO : CLK_OFF;
      ISO:      nxt = done ? SAVE : ISO;
      SAVE:     nxt = SW_OFF;
      SW_OFF:   nxt = (!sw_ack || done) ? OFF : SW_OFF;
      OFF:      nxt = pwr_req ? SW_ON : OFF;
      SW_ON:    nxt = (sw_ack || done) ? RST_HOLD : SW_ON;
      RST_HOLD: nxt = done ? RESTORE : RST_HOLD;
      RESTORE:  nxt = ISO_REL;
      ISO_REL:  nxt = done ? ON : ISO_REL;
      default:  nxt = ON;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ON;
      err   <= 1'b0;
    end else begin
      state <= nxt;
      err   <= err | timeout;
    end
  assign clk_en    = state inside {ON, RST_HOLD, ISO_REL};
  assign iso_en    = !(state inside {ON, CLK_OFF});
  assign sw_en     = !(state inside {SW_OFF, OFF});
  assign dom_rst_n = !(state inside {SW_OFF, OFF, SW_ON, RST_HOLD});
  assign save      = state == SAVE;
  assign restore   = state == RESTORE;
  assign pwr_on    = state == ON;
  assign pwr_off   = state == OFF;
  assign state_o   = state;
endmodule

// File: doc/power_seq_ctrl.md
POWER_SEQ_CTRL -- requirements
Module: power_seq_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 4, cycles each settle step lasts (range 1..255).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 64, max cycles waiting for sw_ack (range 2..65535).
REQ-003 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port pwr_req  input  1  level request, 1 = domain on, 0 = domain off.
REQ-006 SHALL have port dom_idle  input  1  domain quiesced; power-down starts only when 1.
REQ-007 SHALL have port sw_ack  input  1  power-switch rail status, 1 = rails good.
REQ-008 SHALL have ports clk_en, iso_en, save, restore, sw_en, dom_rst_n  output  1 each  ICG enable, isolation clamp, retention save pulse, retention restore pulse, switch enable, domain reset (active-low).
REQ-009 SHALL have ports pwr_on, pwr_off, err  output  1 each  domain fully on, domain fully off, sticky ack-timeout flag.
REQ-010 SHALL have port state_o  output  4  current FSM state encoding.

Function
REQ-011 SHALL implement states ON, CLK_OFF, ISO, SAVE, SW_OFF, OFF, SW_ON, RST_HOLD, RESTORE, ISO_REL; all outputs Moore-decoded from the state register.
REQ-012 SHALL drive per state (clk_en iso_en sw_en dom_rst_n): ON 1 0 1 1; CLK_OFF 0 0 1 1; ISO 0 1 1 1; SAVE 0 1 1 1; SW_OFF 0 1 0 0; OFF 0 1 0 0; SW_ON 0 1 1 0; RST_HOLD 1 1 1 0; RESTORE 0 1 1 1; ISO_REL 1 1 1 1.
REQ-013 SHALL assert save only in SAVE, restore only in RESTORE, pwr_on only in ON, pwr_off only in OFF.
REQ-014 SHALL go ON->CLK_OFF when pwr_req==0 and dom_idle==1; remain ON while dom_idle==0.
REQ-015 SHALL hold CLK_OFF, ISO, RST_HOLD and ISO_REL for exactly SETTLE_CYC cycles each, then advance to ISO, SAVE, RESTORE, ON respectively.
REQ-016 SHALL hold SAVE and RESTORE exactly one cycle; SAVE->SW_OFF, RESTORE->ISO_REL.
REQ-017 SHALL leave SW_OFF for OFF in the cycle after sw_ack==0 is sampled; leave SW_ON for RST_HOLD in the cycle after sw_ack==1 is sampled.
REQ-018 SHALL, if the awaited sw_ack value is not seen within ACK_TIMEOUT cycles of entering SW_OFF or SW_ON, set err and advance as if acknowledged.
REQ-019 SHALL go OFF->SW_ON when pwr_req==1.
REQ-020 SHALL never abort a sequence: pwr_req toggling mid-sequence is ignored until ON or OFF is reached, then re-evaluated that cycle.
REQ-021 SHALL clear err only by reset.
REQ-022 SHALL reload the settle/timeout counter to zero on every state entry; counter SHALL NOT wrap.

Reset
REQ-023 SHALL, on rst_n low, enter ON immediately: clk_en=1, iso_en=0, sw_en=1, dom_rst_n=1, save=0, restore=0, pwr_on=1, pwr_off=0, err=0, counter=0.
REQ-024 SHALL, on reset mid-sequence (any state), return to ON with REQ-023 values regardless of sw_ack.

Structure
REQ-025 SHALL place state enum (4-bit encoding ON=0..ISO_REL=9) and default parameter constants in shared package power_seq_pkg.
REQ-026 SHALL implement the settle/timeout counter as sub-module pwr_seq_timer (load, count, done compare).

Verification (SETTLE_CYC=4, ACK_TIMEOUT=16)
REQ-027 SHALL cover full down/up: pwr_req 1->0 with dom_idle=1, sw_ack follows sw_en after 3 cycles -> clk_en low 1 cycle later, iso_en 4 cycles later, save pulse 1 cycle, pwr_off=1; pwr_req->1 -> restore pulse 1 cycle, iso_en falls, pwr_on=1, err=0.
REQ-028 SHALL cover idle gating: pwr_req=0, dom_idle=0 for 10 cycles -> state_o stays 0, clk_en=1; dom_idle->1 -> CLK_OFF next cycle.
REQ-029 SHALL cover timeout: sw_ack stuck 1 in SW_OFF -> err=1 after 16 cycles, state OFF, err stays 1 through later sequences.
REQ-030 SHALL cover request reversal: pwr_req back to 1 during ISO -> sequence reaches OFF, then SW_ON next cycle, ends ON.
REQ-031 SHALL cover reset mid-sequence: rst_n low in RST_HOLD -> all outputs REQ-023 values without a clock edge.
